// File: rtl/aemb2_fetch.sv
// ---------------------------------------------------------------------------
// aemb2_fetch -- AEMB2 instruction fetch stage
//
// Keeps one program counter per hardware thread, drives the instruction
// Wishbone port and presents the fetched word plus its word address to the
// decode/control stage. Branches resolved in EX redirect the active thread's
// PC; a decode forwarding hazard freezes the presented instruction.
//
// Build option:
//   AEMB2_IFETCH_SKID_EN  - when defined, a word acknowledged while the
//                           pipeline is stalled is parked in a skid register
//                           (FULL state) instead of being discarded and
//                           refetched.
//
// Parameters:
//   AEMB_HTX      - bit 0 set enables the second thread PC (pc1)
//   AEMB_RST_VEC  - reset fetch byte address, bits [1:0] ignored
//
// Ports:
//   gclk, grst    - clock, synchronous active-high reset
//   iwb_adr_o     - instruction bus word address (active PC), combinational
//   iwb_stb_o     - instruction bus strobe (FETCH state)
//   iwb_ack_i     - instruction bus acknowledge
//   iwb_dat_i     - instruction bus read data
//   ich_dat       - instruction word presented to decode (registered)
//   rpc_if        - word address of ich_dat (registered)
//   iena          - a fresh word is available this cycle
//   bra_ex        - EX branch status: [1] taken, [0] delay slot
//   alu_ex        - EX result, branch target when bra_ex[1]
//   hzd_fwd       - decode forwarding hazard, replay current instruction
//   dena          - global pipeline advance enable
//   gpha          - thread phase, 1 selects thread 1 when AEMB_HTX[0]=1
// ---------------------------------------------------------------------------
module aemb2_fetch #(
  parameter int unsigned AEMB_HTX     = 1,
  parameter logic [31:0] AEMB_RST_VEC = 32'h0000_0000
) (
  input  logic        gclk,
  input  logic        grst,
  output logic [29:0] iwb_adr_o,
  output logic        iwb_stb_o,
  input  logic        iwb_ack_i,
  input  logic [31:0] iwb_dat_i,
  output logic [31:0] ich_dat,
  output logic [29:0] rpc_if,
  output logic        iena,
  input  logic [1:0]  bra_ex,
  input  logic [31:0] alu_ex,
  input  logic        hzd_fwd,
  input  logic        dena,
  input  logic        gpha
);

  localparam logic [31:0] NOP_WORD = 32'h8800_0000;
  localparam logic [29:0] RST_PC   = AEMB_RST_VEC[31:2];
  localparam logic        HTX_EN   = ((AEMB_HTX & 32'd1) != 32'd0);

`ifdef AEMB2_IFETCH_SKID_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_e;
`endif

  // 30-bit word-address increment; wraps from 0x3FFFFFFF to 0.
  function automatic logic [29:0] pc_inc(input logic [29:0] pc);
    return pc + 30'd1;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] ich_q, ich_d;
  logic [29:0] rpc_q, rpc_d;
  logic [29:0] pc0_q, pc0_d;
  logic [29:0] pc1_q, pc1_d;
`ifdef AEMB2_IFETCH_SKID_EN
  logic [31:0] skid_q, skid_d;
  logic [29:0] skid_pc_q, skid_pc_d;
`endif

  logic        sel_s;
  logic        adv_s;
  logic        inc_s;
  logic [29:0] pc_act_s;
  logic [29:0] pc_new_s;

  // Delay-slot flag and target byte offset are irrelevant to fetch.
  logic        unused_s;
  assign unused_s = bra_ex[0] ^ (^alu_ex[1:0]);

  assign sel_s    = gpha & HTX_EN;
  assign pc_act_s = sel_s ? pc1_q : pc0_q;
  assign adv_s    = dena & ~hzd_fwd;

  assign ich_dat = ich_q;
  assign rpc_if  = rpc_q;

  // Bus-side outputs: pure functions of state and PC, no path from read data.
  always_comb begin
    iwb_adr_o = pc_act_s;
    iwb_stb_o = (state_q == ST_FETCH);
    iena      = (state_q == ST_FETCH) & iwb_ack_i;
`ifdef AEMB2_IFETCH_SKID_EN
    iena      = iena | (state_q == ST_FULL);
`endif
  end

  // Next-state, capture and PC-increment decision.
  always_comb begin
    state_d = state_q;
    ich_d   = ich_q;
    rpc_d   = rpc_q;
    inc_s   = 1'b0;
`ifdef AEMB2_IFETCH_SKID_EN
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Late acks from a transaction cut short by reset are ignored here.
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (iwb_ack_i && adv_s) begin
          ich_d = iwb_dat_i;
          rpc_d = pc_act_s;
          inc_s = 1'b1;
        end
`ifdef AEMB2_IFETCH_SKID_EN
        else if (iwb_ack_i) begin
          // Park the word; PC stays on it so it is counted when delivered.
          skid_d    = iwb_dat_i;
          skid_pc_d = pc_act_s;
          state_d   = ST_FULL;
        end
`endif
        else begin
          // Without a skid the word (if any) is dropped and refetched.
          state_d = ST_FETCH;
        end
      end
`ifdef AEMB2_IFETCH_SKID_EN
      ST_FULL: begin
        if (adv_s) begin
          ich_d   = skid_q;
          rpc_d   = skid_pc_q;
          state_d = ST_FETCH;
          // If a branch redirected the PC while parked, the PC no longer
          // points at the skid word and must not be stepped past the target.
          inc_s   = (pc_act_s == skid_pc_q);
        end else begin
          state_d = ST_FULL;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // PC update for the active thread only; branch has priority over increment.
  always_comb begin
    pc0_d = pc0_q;
    pc1_d = pc1_q;
    if (dena && bra_ex[1]) begin
      pc_new_s = alu_ex[31:2];
    end else if (inc_s) begin
      pc_new_s = pc_inc(pc_act_s);
    end else begin
      pc_new_s = pc_act_s;
    end
    if (sel_s) begin
      pc1_d = pc_new_s;
    end else begin
      pc0_d = pc_new_s;
    end
  end

  // State, presented instruction and PC registers.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q <= ST_IDLE;
      ich_q   <= NOP_WORD;
      rpc_q   <= RST_PC;
      pc0_q   <= RST_PC;
      pc1_q   <= RST_PC;
    end else begin
      state_q <= state_d;
      ich_q   <= ich_d;
      rpc_q   <= rpc_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
    end
  end

`ifdef AEMB2_IFETCH_SKID_EN
  // Skid buffer for a word acknowledged while the pipeline was stalled.
  always_ff @(posedge gclk) begin
    if (grst) begin
      skid_q    <= 32'h0000_0000;
      skid_pc_q <= 30'd0;
    end else begin
      skid_q    <= skid_d;
      skid_pc_q <= skid_pc_d;
    end
  end
`endif

endmodule

// File: tb/tb_aemb2_fetch.sv
// ---------------------------------------------------------------------------
// tb_aemb2_fetch -- directed self-checking bench for aemb2_fetch.
// Zero-wait instruction slave returning {2'b01, word address}; reset vector
// 0x100 (word 0x40); both threads enabled.
// ---------------------------------------------------------------------------
module tb_aemb2_fetch;

  logic        gclk = 1'b0;
  logic        grst;
  logic [29:0] iwb_adr_o;
  logic        iwb_stb_o;
  logic        iwb_ack_i;
  logic [31:0] iwb_dat_i;
  logic [31:0] ich_dat;
  logic [29:0] rpc_if;
  logic        iena;
  logic [1:0]  bra_ex;
  logic [31:0] alu_ex;
  logic        hzd_fwd;
  logic        dena;
  logic        gpha;
  logic        ack_force;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP_WORD = 32'h8800_0000;
`ifdef AEMB2_IFETCH_SKID_EN
  localparam logic [31:0] STALL_STB = 32'd0;
`else
  localparam logic [31:0] STALL_STB = 32'd1;
`endif

  aemb2_fetch #(
    .AEMB_HTX     (1),
    .AEMB_RST_VEC (32'h0000_0100)
  ) dut (
    .gclk      (gclk),
    .grst      (grst),
    .iwb_adr_o (iwb_adr_o),
    .iwb_stb_o (iwb_stb_o),
    .iwb_ack_i (iwb_ack_i),
    .iwb_dat_i (iwb_dat_i),
    .ich_dat   (ich_dat),
    .rpc_if    (rpc_if),
    .iena      (iena),
    .bra_ex    (bra_ex),
    .alu_ex    (alu_ex),
    .hzd_fwd   (hzd_fwd),
    .dena      (dena),
    .gpha      (gpha)
  );

  always #5 gclk = ~gclk;

  assign iwb_ack_i = iwb_stb_o | ack_force;
  assign iwb_dat_i = {2'b01, iwb_adr_o};

  function automatic logic [31:0] dat_of(input logic [29:0] a);
    return {2'b01, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic [29:0] adr,
                           input logic [31:0] dat, input logic [29:0] rpc);
    chk({tag, "_adr"}, {2'b00, iwb_adr_o}, {2'b00, adr});
    chk({tag, "_ich"}, ich_dat, dat);
    chk({tag, "_rpc"}, {2'b00, rpc_if}, {2'b00, rpc});
  endtask

  task automatic tick;
    @(posedge gclk);
    #1;
  endtask

  initial begin
    grst = 1'b1; dena = 1'b1; hzd_fwd = 1'b0; bra_ex = 2'b00;
    alu_ex = 32'h0000_0000; gpha = 1'b0; ack_force = 1'b0;
    tick; tick;
    #1;
    chk("rst_stb",  {31'd0, iwb_stb_o}, 32'd0);
    chk("rst_iena", {31'd0, iena}, 32'd0);
    chk_fetch("rst", 30'h40, NOP_WORD, 30'h40);

    grst = 1'b0;
    tick;
    #1;
    chk("first_stb",  {31'd0, iwb_stb_o}, 32'd1);
    chk("first_iena", {31'd0, iena}, 32'd1);
    chk("first_ich",  ich_dat, NOP_WORD);

    // Sequential zero-wait stream.
    for (int k = 0; k < 4; k++) begin
      tick;
      #1;
      chk_fetch("seq", 30'h41 + 30'(k), dat_of(30'h40 + 30'(k)), 30'h40 + 30'(k));
      chk("seq_iena", {31'd0, iena}, 32'd1);
    end

    // Taken branch without delay slot: fall-through still presented once.
    bra_ex = 2'b10; alu_ex = 32'h0000_2000;
    tick;
    bra_ex = 2'b00;
    #1;
    chk_fetch("bra_ft", 30'h800, dat_of(30'h44), 30'h44);
    tick;
    #1;
    chk_fetch("bra_tgt", 30'h801, dat_of(30'h800), 30'h800);

    // Forwarding hazard for three cycles.
    hzd_fwd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      #1;
      chk_fetch("hzd", 30'h801, dat_of(30'h800), 30'h800);
      chk("hzd_iena", {31'd0, iena}, 32'd1);
    end
    hzd_fwd = 1'b0;
    tick;
    #1;
    chk_fetch("hzd_rel", 30'h802, dat_of(30'h801), 30'h801);

    // Ack while dena=0.
    dena = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick;
      #1;
      chk("stall_stb", {31'd0, iwb_stb_o}, STALL_STB);
      chk_fetch("stall", 30'h802, dat_of(30'h801), 30'h801);
    end
    dena = 1'b1;
    tick;
    #1;
    chk_fetch("stall_rel", 30'h803, dat_of(30'h802), 30'h802);

    // PC wrap at the top of the address space.
    bra_ex = 2'b10; alu_ex = 32'hFFFF_FFFC;
    tick;
    bra_ex = 2'b00;
    #1;
    chk_fetch("wrap_bra", 30'h3FFF_FFFF, dat_of(30'h803), 30'h803);
    tick;
    #1;
    chk_fetch("wrap", 30'h0, dat_of(30'h3FFF_FFFF), 30'h3FFF_FFFF);

    // Second thread: branch thread 1 while thread 0 keeps its run.
    gpha = 1'b1;
    #1;
    chk("t1_adr0", {2'b00, iwb_adr_o}, 32'h40);
    bra_ex = 2'b10; alu_ex = 32'h0000_4000;
    tick;
    bra_ex = 2'b00;
    #1;
    chk_fetch("t1_bra", 30'h1000, dat_of(30'h40), 30'h40);
    gpha = 1'b0;
    #1;
    chk("t0_adr0", {2'b00, iwb_adr_o}, 32'h0);
    tick;
    #1;
    chk_fetch("t0_seq", 30'h1, dat_of(30'h0), 30'h0);
    gpha = 1'b1;
    #1;
    chk("t1_adr1", {2'b00, iwb_adr_o}, 32'h1000);
    tick;
    #1;
    chk_fetch("t1_seq", 30'h1001, dat_of(30'h1000), 30'h1000);
    gpha = 1'b0;
    #1;
    chk("t0_adr1", {2'b00, iwb_adr_o}, 32'h1);

    // Reset during an outstanding strobe, then a late ack in IDLE.
    grst = 1'b1;
    tick;
    #1;
    chk("mrst_stb",  {31'd0, iwb_stb_o}, 32'd0);
    chk("mrst_iena", {31'd0, iena}, 32'd0);
    chk_fetch("mrst", 30'h40, NOP_WORD, 30'h40);
    grst = 1'b0; ack_force = 1'b1;
    #1;
    chk("late_ack_iena", {31'd0, iena}, 32'd0);
    tick;
    ack_force = 1'b0;
    #1;
    chk("late_ack_ich", ich_dat, NOP_WORD);
    chk("late_ack_stb", {31'd0, iwb_stb_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
